// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared types and encodings for the multicycle MIPS controller
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_IF,
      ST_ID,
      ST_MEM_ADDR,
      ST_LW_MEM,
      ST_LW_WB,
      ST_SW_MEM,
      ST_R_EX,
      ST_R_WB,
      ST_I_EX,
      ST_I_WB,
      ST_BEQ,
      ST_BNE,
      ST_J,
      ST_JAL,
      ST_JR,
      ST_ILL
   } state_e;

   // Selects how the ALU decoder derives its operation.
   typedef enum logic [1:0] {
      CLS_ADD,
      CLS_SUB,
      CLS_RTYPE,
      CLS_ITYPE
   } alu_cls_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_JR  = 6'b001000;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] SRCB_B    = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_BR   = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;
   localparam logic [1:0] PCSRC_REG    = 2'b11;

endpackage

// File: rtl/mc_alu_dec.sv
// rtl/mc_alu_dec.sv - ALU operation and immediate-extension decoder
module mc_alu_dec
   import mc_ctrl_pkg::*;
#(
   parameter int ALU_W = 3
) (
   input  logic [1:0]       cls_i,
   input  logic [5:0]       opcode_i,
   input  logic [5:0]       func_i,
   output logic [ALU_W-1:0] alu_operation_o,
   output logic             zero_ext_o
);

   logic [2:0] op;

   // Map the requested class to an ALU code; unknown funcs/opcodes fall back to add.
   always_comb begin
      op         = ALU_ADD;
      zero_ext_o = 1'b0;
      case (alu_cls_e'(cls_i))
         CLS_SUB: op = ALU_SUB;
         CLS_RTYPE: begin
            case (func_i)
               FN_SUB:  op = ALU_SUB;
               FN_AND:  op = ALU_AND;
               FN_OR:   op = ALU_OR;
               FN_SLT:  op = ALU_SLT;
               default: op = ALU_ADD;
            endcase
         end
         CLS_ITYPE: begin
            case (opcode_i)
               OP_ANDI: begin op = ALU_AND; zero_ext_o = 1'b1; end
               OP_ORI:  begin op = ALU_OR;  zero_ext_o = 1'b1; end
               OP_SLTI: op = ALU_SLT;
               default: op = ALU_ADD;
            endcase
         end
         default: op = ALU_ADD;
      endcase
   end

   assign alu_operation_o = ALU_W'(op);

endmodule

// File: rtl/mc_main_ctrl.sv
// rtl/mc_main_ctrl.sv - multicycle MIPS main FSM with configurable memory latency
module mc_main_ctrl
   import mc_ctrl_pkg::*;
#(
   parameter int MEM_LAT = 1,
   parameter int ALU_W   = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic [5:0]       func,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic             branch_ne,
   output logic             iord,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             mem_to_reg,
   output logic             reg_write,
   output logic             reg_dst,
   output logic             link,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic             zero_ext,
   output logic [1:0]       pc_src,
   output logic [ALU_W-1:0] alu_operation,
   output logic             illegal
);

   localparam int             CW       = $clog2(MEM_LAT + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(MEM_LAT - 1);

   state_e        state_q, state_d, state_v;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          store_q, store_d;
   logic          mem_state, cnt_done;
   alu_cls_e      cls;

   assign mem_state = (state_q == ST_IF) || (state_q == ST_LW_MEM) || (state_q == ST_SW_MEM);
   assign cnt_done  = (cnt_q == CNT_LAST);

   // State, wait counter and lw/sw flag registers; reset restarts the fetch from scratch.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IF;
         cnt_q   <= '0;
         store_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         store_q <= store_d;
      end
   end

   // Next-state: memory states wait for the counter, ID dispatches on opcode/func.
   always_comb begin
      state_d = state_q;
      store_d = store_q;
      cnt_d   = (mem_state && !cnt_done) ? cnt_q + CW'(1) : '0;
      case (state_q)
         ST_IF:       if (cnt_done) state_d = ST_ID;
         ST_ID: begin
            store_d = (opcode == OP_SW);
            case (opcode)
               OP_RTYPE: begin
                  if (func == FN_JR)
                     state_d = ST_JR;
                  else if (func inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT})
                     state_d = ST_R_EX;
                  else
                     state_d = ST_ILL;
               end
               OP_LW, OP_SW:                     state_d = ST_MEM_ADDR;
               OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = ST_I_EX;
               OP_BEQ:                           state_d = ST_BEQ;
               OP_BNE:                           state_d = ST_BNE;
               OP_J:                             state_d = ST_J;
               OP_JAL:                           state_d = ST_JAL;
               default:                          state_d = ST_ILL;
            endcase
         end
         ST_MEM_ADDR: state_d = store_q ? ST_SW_MEM : ST_LW_MEM;
         ST_LW_MEM:   if (cnt_done) state_d = ST_LW_WB;
         ST_SW_MEM:   if (cnt_done) state_d = ST_IF;
         ST_R_EX:     state_d = ST_R_WB;
         ST_I_EX:     state_d = ST_I_WB;
         default:     state_d = ST_IF;
      endcase
   end

   // Moore outputs; during reset the IF view is shown with every write strobe suppressed.
   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      branch_ne     = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      link          = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_B;
      pc_src        = PCSRC_ALU;
      illegal       = 1'b0;
      cls           = CLS_ADD;
      state_v       = rst ? ST_IF : state_q;
      case (state_v)
         ST_IF: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            if (cnt_done) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
            end
         end
         ST_ID:       alu_src_b = SRCB_BR;
         ST_MEM_ADDR: begin alu_src_a = 1'b1; alu_src_b = SRCB_IMM; end
         ST_LW_MEM:   begin mem_read = 1'b1; iord = 1'b1; end
         ST_LW_WB:    begin reg_write = 1'b1; mem_to_reg = 1'b1; end
         ST_SW_MEM:   begin mem_write = 1'b1; iord = 1'b1; end
         ST_R_EX:     begin alu_src_a = 1'b1; cls = CLS_RTYPE; end
         ST_R_WB:     begin reg_write = 1'b1; reg_dst = 1'b1; end
         ST_I_EX:     begin alu_src_a = 1'b1; alu_src_b = SRCB_IMM; cls = CLS_ITYPE; end
         ST_I_WB:     begin reg_write = 1'b1; cls = CLS_ITYPE; end
         ST_BEQ, ST_BNE: begin
            alu_src_a     = 1'b1;
            cls           = CLS_SUB;
            pc_write_cond = 1'b1;
            pc_src        = PCSRC_ALUOUT;
            branch_ne     = (state_v == ST_BNE);
         end
         ST_J:        begin pc_write = 1'b1; pc_src = PCSRC_JUMP; end
         ST_JAL:      begin pc_write = 1'b1; pc_src = PCSRC_JUMP; link = 1'b1; reg_write = 1'b1; end
         ST_JR:       begin pc_write = 1'b1; pc_src = PCSRC_REG; end
         ST_ILL:      illegal = 1'b1;
         default:     ;
      endcase
      if (rst) begin
         pc_write      = 1'b0;
         pc_write_cond = 1'b0;
         ir_write      = 1'b0;
         reg_write     = 1'b0;
         mem_write     = 1'b0;
      end
   end

   mc_alu_dec #(.ALU_W(ALU_W)) u_alu_dec (
      .cls_i           (cls),
      .opcode_i        (opcode),
      .func_i          (func),
      .alu_operation_o (alu_operation),
      .zero_ext_o      (zero_ext)
   );

endmodule

// File: tb/tb_mc_main_ctrl.sv
// tb/tb_mc_main_ctrl.sv - self-checking bench for mc_main_ctrl at memory latencies 1 and 3
module tb_mc_main_ctrl;

   localparam int K_IF = 0, K_IFL = 1, K_ID = 2, K_MA = 3, K_LWM = 4, K_LWWB = 5, K_SWM = 6,
                  K_REX = 7, K_RWB = 8, K_IEX = 9, K_IWB = 10, K_BEQ = 11, K_BNE = 12,
                  K_J = 13, K_JAL = 14, K_JR = 15, K_ILL = 16;

   localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                          OP_ADDI = 6'b001000, OP_ANDI = 6'b001100, OP_ORI = 6'b001101,
                          OP_SLTI = 6'b001010, OP_BEQ = 6'b000100, OP_BNE = 6'b000101,
                          OP_J = 6'b000010, OP_JAL = 6'b000011;
   localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_AND = 6'b100100,
                          FN_OR = 6'b100101, FN_SLT = 6'b101010, FN_JR = 6'b001000;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] opcode = 6'd0;
   logic [5:0] func = 6'd0;
   wire [20:0] o1, o3;

   int n_checks = 0;
   int n_fail   = 0;
   int lat_sel  = 1;

   logic [20:0] exp_q[$];
   int          kind_q[$];

   always #5 clk = ~clk;

   mc_main_ctrl #(.MEM_LAT(1), .ALU_W(3)) u_dut1 (
      .clk(clk), .rst(rst), .opcode(opcode), .func(func),
      .pc_write(o1[20]), .pc_write_cond(o1[19]), .branch_ne(o1[18]), .iord(o1[17]),
      .mem_read(o1[16]), .mem_write(o1[15]), .ir_write(o1[14]), .mem_to_reg(o1[13]),
      .reg_write(o1[12]), .reg_dst(o1[11]), .link(o1[10]), .alu_src_a(o1[9]),
      .alu_src_b(o1[8:7]), .zero_ext(o1[6]), .pc_src(o1[5:4]), .alu_operation(o1[3:1]),
      .illegal(o1[0])
   );

   mc_main_ctrl #(.MEM_LAT(3), .ALU_W(3)) u_dut3 (
      .clk(clk), .rst(rst), .opcode(opcode), .func(func),
      .pc_write(o3[20]), .pc_write_cond(o3[19]), .branch_ne(o3[18]), .iord(o3[17]),
      .mem_read(o3[16]), .mem_write(o3[15]), .ir_write(o3[14]), .mem_to_reg(o3[13]),
      .reg_write(o3[12]), .reg_dst(o3[11]), .link(o3[10]), .alu_src_a(o3[9]),
      .alu_src_b(o3[8:7]), .zero_ext(o3[6]), .pc_src(o3[5:4]), .alu_operation(o3[3:1]),
      .illegal(o3[0])
   );

   function automatic logic [20:0] dut_out();
      return (lat_sel == 3) ? o3 : o1;
   endfunction

   function automatic logic [2:0] rop(input logic [5:0] fn);
      case (fn)
         FN_SUB:  return 3'b110;
         FN_AND:  return 3'b000;
         FN_OR:   return 3'b001;
         FN_SLT:  return 3'b111;
         default: return 3'b010;
      endcase
   endfunction

   function automatic logic [2:0] iop(input logic [5:0] opc);
      case (opc)
         OP_ANDI: return 3'b000;
         OP_ORI:  return 3'b001;
         OP_SLTI: return 3'b111;
         default: return 3'b010;
      endcase
   endfunction

   // Reference output vector for one cycle of a given step, straight from the control table.
   function automatic logic [20:0] exp_out(input int k, input logic [5:0] opc, input logic [5:0] fn);
      logic pw, pwc, bn, io, mr, mw, irw, m2r, rw, rd, lnk, asa, zx, ill;
      logic [1:0] asb, pcs;
      logic [2:0] op;
      pw = 0; pwc = 0; bn = 0; io = 0; mr = 0; mw = 0; irw = 0; m2r = 0;
      rw = 0; rd = 0; lnk = 0; asa = 0; zx = 0; ill = 0;
      asb = 2'b00; pcs = 2'b00; op = 3'b010;
      case (k)
         K_IF, K_IFL: begin mr = 1; asb = 2'b01; if (k == K_IFL) begin irw = 1; pw = 1; end end
         K_ID:   asb = 2'b11;
         K_MA:   begin asa = 1; asb = 2'b10; end
         K_LWM:  begin mr = 1; io = 1; end
         K_LWWB: begin rw = 1; m2r = 1; end
         K_SWM:  begin mw = 1; io = 1; end
         K_REX:  begin asa = 1; op = rop(fn); end
         K_RWB:  begin rw = 1; rd = 1; end
         K_IEX:  begin asa = 1; asb = 2'b10; op = iop(opc); zx = (opc == OP_ANDI) || (opc == OP_ORI); end
         K_IWB:  begin rw = 1; op = iop(opc); zx = (opc == OP_ANDI) || (opc == OP_ORI); end
         K_BEQ, K_BNE: begin asa = 1; op = 3'b110; pwc = 1; pcs = 2'b01; bn = (k == K_BNE); end
         K_J:    begin pw = 1; pcs = 2'b10; end
         K_JAL:  begin pw = 1; pcs = 2'b10; lnk = 1; rw = 1; end
         K_JR:   begin pw = 1; pcs = 2'b11; end
         K_ILL:  ill = 1;
         default: ;
      endcase
      return {pw, pwc, bn, io, mr, mw, irw, m2r, rw, rd, lnk, asa, asb, zx, pcs, op, ill};
   endfunction

   // Expected per-cycle sequence of one whole instruction, starting at its fetch.
   task automatic build_seq(input int lat, input logic [5:0] opc, input logic [5:0] fn);
      exp_q.delete();
      kind_q.delete();
      for (int i = 0; i < lat; i++) kind_q.push_back((i == lat - 1) ? K_IFL : K_IF);
      kind_q.push_back(K_ID);
      case (opc)
         OP_R: begin
            if (fn == FN_JR) kind_q.push_back(K_JR);
            else if (fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT}) begin
               kind_q.push_back(K_REX); kind_q.push_back(K_RWB);
            end else kind_q.push_back(K_ILL);
         end
         OP_LW: begin
            kind_q.push_back(K_MA);
            for (int i = 0; i < lat; i++) kind_q.push_back(K_LWM);
            kind_q.push_back(K_LWWB);
         end
         OP_SW: begin
            kind_q.push_back(K_MA);
            for (int i = 0; i < lat; i++) kind_q.push_back(K_SWM);
         end
         OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin kind_q.push_back(K_IEX); kind_q.push_back(K_IWB); end
         OP_BEQ: kind_q.push_back(K_BEQ);
         OP_BNE: kind_q.push_back(K_BNE);
         OP_J:   kind_q.push_back(K_J);
         OP_JAL: kind_q.push_back(K_JAL);
         default: kind_q.push_back(K_ILL);
      endcase
      foreach (kind_q[i]) exp_q.push_back(exp_out(kind_q[i], opc, fn));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      opcode = 6'($urandom);
      func = 6'($urandom);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         #1;
         n_checks++;
         if (o1 !== exp_out(K_IF, opcode, func)) begin
            n_fail++;
            $display("FAIL reset_lat1 cyc %0d: got %b want %b", c, o1, exp_out(K_IF, opcode, func));
         end
         n_checks++;
         if (o3 !== exp_out(K_IF, opcode, func)) begin
            n_fail++;
            $display("FAIL reset_lat3 cyc %0d: got %b want %b", c, o3, exp_out(K_IF, opcode, func));
         end
      end
   endtask

   task automatic test_rtype_add();
      lat_sel = 1;
      do_reset();
      opcode = OP_R;
      func = FN_ADD;
      build_seq(1, opcode, func);
      for (int i = 0; i < exp_q.size(); i++) begin
         #1;
         n_checks++;
         if (dut_out() !== exp_q[i]) begin
            n_fail++;
            $display("FAIL rtype_add step %0d kind %0d: got %b want %b", i, kind_q[i], dut_out(), exp_q[i]);
         end
         @(negedge clk);
      end
      #1;
      n_checks++;
      if (dut_out() !== exp_out(K_IFL, opcode, func)) begin
         n_fail++;
         $display("FAIL rtype_add_return: got %b want %b", dut_out(), exp_out(K_IFL, opcode, func));
      end
   endtask

   task automatic test_lw_lat3();
      lat_sel = 3;
      do_reset();
      opcode = OP_LW;
      func = 6'($urandom);
      build_seq(3, opcode, func);
      for (int i = 0; i < exp_q.size(); i++) begin
         #1;
         n_checks++;
         if (dut_out() !== exp_q[i]) begin
            n_fail++;
            $display("FAIL lw_lat3 step %0d kind %0d: got %b want %b", i, kind_q[i], dut_out(), exp_q[i]);
         end
         @(negedge clk);
      end
      #1;
      n_checks++;
      if (dut_out() !== exp_out(K_IF, opcode, func)) begin
         n_fail++;
         $display("FAIL lw_lat3_return: got %b want %b", dut_out(), exp_out(K_IF, opcode, func));
      end
   endtask

   // Runs a fixed list of instructions back to back on the selected latency.
   task automatic test_list(input string name, input int lat, input logic [11:0] prog[]);
      lat_sel = lat;
      do_reset();
      foreach (prog[p]) begin
         opcode = prog[p][11:6];
         func = prog[p][5:0];
         build_seq(lat, opcode, func);
         for (int i = 0; i < exp_q.size(); i++) begin
            #1;
            n_checks++;
            if (dut_out() !== exp_q[i]) begin
               n_fail++;
               $display("FAIL %s instr %0d step %0d kind %0d: got %b want %b",
                        name, p, i, kind_q[i], dut_out(), exp_q[i]);
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_branches();
      logic [11:0] prog[];
      prog = '{{OP_BNE, 6'd5}, {OP_BEQ, 6'd9}};
      test_list("branches", 1, prog);
   endtask

   task automatic test_jal_jr();
      logic [11:0] prog[];
      prog = '{{OP_JAL, 6'd0}, {OP_R, FN_JR}, {OP_J, 6'd3}};
      test_list("jal_jr", 1, prog);
   endtask

   task automatic test_itype();
      logic [11:0] prog[];
      prog = '{{OP_ANDI, 6'd1}, {OP_SLTI, 6'd2}, {OP_ADDI, 6'd3}, {OP_ORI, 6'd4}};
      test_list("itype", 1, prog);
   endtask

   task automatic test_illegal();
      logic [11:0] prog[];
      prog = '{{6'b111111, FN_ADD}, {OP_R, 6'b000111}, {OP_R, FN_SLT}};
      test_list("illegal_lat1", 1, prog);
      test_list("illegal_lat3", 3, prog);
   endtask

   // Reset lands in the second wait cycle of a memory state, then a full instruction must follow.
   task automatic test_reset_midwait(input logic [5:0] opc);
      lat_sel = 3;
      do_reset();
      opcode = opc;
      func = 6'd0;
      build_seq(3, opcode, func);
      for (int i = 0; i < 6; i++) begin
         #1;
         n_checks++;
         if (dut_out() !== exp_q[i]) begin
            n_fail++;
            $display("FAIL midwait_pre op %b step %0d: got %b want %b", opc, i, dut_out(), exp_q[i]);
         end
         @(negedge clk);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if (dut_out() !== exp_out(K_IF, opcode, func)) begin
         n_fail++;
         $display("FAIL midwait_rst op %b: got %b want %b", opc, dut_out(), exp_out(K_IF, opcode, func));
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) begin
         #1;
         n_checks++;
         if (dut_out() !== exp_q[i]) begin
            n_fail++;
            $display("FAIL midwait_post op %b step %0d: got %b want %b", opc, i, dut_out(), exp_q[i]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_random(input int lat, input int n);
      logic [5:0] ops[13];
      logic [5:0] fns[6];
      ops = '{OP_R, OP_R, OP_R, OP_LW, OP_SW, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI,
              OP_BEQ, OP_BNE, OP_J, OP_JAL};
      fns = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_JR};
      lat_sel = lat;
      do_reset();
      for (int p = 0; p < n; p++) begin
         opcode = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 12)];
         func = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
         build_seq(lat, opcode, func);
         for (int i = 0; i < exp_q.size(); i++) begin
            #1;
            n_checks++;
            if (dut_out() !== exp_q[i]) begin
               n_fail++;
               $display("FAIL random_lat%0d instr %0d op %b fn %b step %0d: got %b want %b",
                        lat, p, opcode, func, i, dut_out(), exp_q[i]);
            end
            @(negedge clk);
         end
      end
   endtask

   initial begin
      test_reset();
      test_rtype_add();
      test_lw_lat3();
      test_branches();
      test_jal_jr();
      test_itype();
      test_illegal();
      test_reset_midwait(OP_LW);
      test_reset_midwait(OP_SW);
      test_random(1, 60);
      test_random(3, 60);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
